serial_frame_tx: RTL and testbench

- Parallel-to-serial frame transmitter, the sending end of the lab's serial link.
- Accepts a DATA_W-bit word through a valid/ready handshake and latches it.
- Drives the word out on a single line as start bit, data bits LSB first, then a stop bit; each bit is held for BIT_CYCLES clocks.
- All state is falling-edge clocked, so the block drops into the existing flip-flop-based lab designs.

---
 rtl/serial_frame_tx.sv | 170 +++++++++++++++++
 tb/tb_serial_frame_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter (start, LSB-first data,
// [parity], stop), each bit held BIT_CYCLES clocks. All state is updated on the
// falling edge of clk. Reset is asynchronous and active-high.
// Optional even-parity bit: define SERIAL_TX_PARITY_EN.
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              out_q, out_n;
  logic              ready_q, ready_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              cnt_last;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_n;
`endif

  assign cnt_last = (cnt == CNT_LAST);

  // State, counters, shift register and registered outputs (falling edge).
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      out_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      out_q   <= out_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  // Next-state logic; the line value is computed one edge ahead so tx_out is
  // a flop and goes low on the very edge that accepts the word.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    out_n   = out_q;
    ready_n = ready_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_n   = par_q;
`endif
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          shreg_n = tx_data;
`ifdef SERIAL_TX_PARITY_EN
          par_n   = ^tx_data;
`endif
          cnt_n   = '0;
          idx_n   = '0;
          state_n = START;
          out_n   = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = DATA;
          out_n   = shreg[0];
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_n   = '0;
          shreg_n = shreg >> 1;
          if (idx == IDX_LAST) begin
            idx_n = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_n = PARITY;
            out_n   = par_q;
`else
            state_n = STOP;
            out_n   = 1'b1;
`endif
          end else begin
            idx_n = idx + IDX_W'(1);
            out_n = shreg_n[0];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = STOP;
          out_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = IDLE;
          out_n   = 1'b1;
          ready_n = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        out_n   = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign tx_out   = out_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench for serial_frame_tx (BIT_CYCLES=4 and 1).
module tb_serial_frame_tx;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1;
  logic       tx_ready0, tx_out0, busy0, done0;
  logic       tx_ready1, tx_out1, busy1, done1;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_LEN = NBITS * 4;

  typedef struct packed {
    logic out;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   tests = 0;
  int   fails = 0;
  int   busy_run = 0;

  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx_out(tx_out0), .busy(busy0), .done(done0)
  );

  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx_out(tx_out1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-edge line/flag values for one frame, plus the done edge.
  task automatic push_frame(input int which, input logic [7:0] w);
    logic [10:0] fb;
    int n;
    int bc;
    exp_t e;
    bc = (which == 0) ? 4 : 1;
    fb = '0;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1 + i] = w[i];
    n = 9;
`ifdef SERIAL_TX_PARITY_EN
    fb[n] = ^w;
    n++;
`endif
    fb[n] = 1'b1;
    n++;
    for (int b = 0; b < n; b++)
      for (int c = 0; c < bc; c++) begin
        e = '{out: fb[b], busy: 1'b1, done: 1'b0, ready: 1'b0};
        if (which == 0) sb0.push_back(e); else sb1.push_back(e);
      end
    e = '{out: 1'b1, busy: 1'b0, done: 1'b1, ready: 1'b1};
    if (which == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  task automatic push_idle(input int which, input int n);
    exp_t e;
    e = '{out: 1'b1, busy: 1'b0, done: 1'b0, ready: 1'b1};
    for (int i = 0; i < n; i++)
      if (which == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  // Drive inputs on the rising edge, check just after the falling edge.
  task automatic step(input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1);
    exp_t e;
    @(posedge clk);
    tx_valid0 = v0; tx_data0 = d0;
    tx_valid1 = v1; tx_data1 = d1;
    @(negedge clk);
    #1;
    if (busy0 === 1'b1) busy_run++;
    if (sb0.size() == 0) begin
      chk("sb0_underflow", 32'd1, 32'd0);
    end else begin
      e = sb0.pop_front();
      chk("tx_out", {31'd0, tx_out0}, {31'd0, e.out});
      chk("busy", {31'd0, busy0}, {31'd0, e.busy});
      chk("done", {31'd0, done0}, {31'd0, e.done});
      chk("tx_ready", {31'd0, tx_ready0}, {31'd0, e.ready});
    end
    if (sb1.size() != 0) begin
      e = sb1.pop_front();
      chk("bc1_tx_out", {31'd0, tx_out1}, {31'd0, e.out});
      chk("bc1_busy", {31'd0, busy1}, {31'd0, e.busy});
      chk("bc1_done", {31'd0, done1}, {31'd0, e.done});
    end
  endtask

  initial begin
    tx_valid0 = 1'b0; tx_data0 = '0;
    tx_valid1 = 1'b0; tx_data1 = '0;
    reset = 1'b1;
    #1;
    chk("rst_tx_out", {31'd0, tx_out0}, 32'd1);
    chk("rst_tx_ready", {31'd0, tx_ready0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_bc1_tx_out", {31'd0, tx_out1}, 32'd1);
    #2 reset = 1'b0;

    // Single frame 0xA5 with scrambled tx_data after acceptance.
    push_idle(0, 1);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    push_frame(0, 8'hA5);
    push_idle(0, 1);
    busy_run = 0;
    step(1'b1, 8'hA5, 1'b0, 8'h00);
    while (sb0.size() > 0) step(1'b0, 8'($urandom), 1'b0, 8'h00);
    chk("frame_len_a5", busy_run, FRAME_LEN);

    // Back-to-back 0x3C then 0xFF; tx_valid/tx_data toggle during frame 1.
    push_frame(0, 8'h3C);
    push_frame(0, 8'hFF);
    push_idle(0, 1);
    step(1'b1, 8'h3C, 1'b0, 8'h00);
    while (sb0.size() > FRAME_LEN + 2)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 8'h00);
    step(1'b1, 8'hFF, 1'b0, 8'h00);
    while (sb0.size() > 0) step(1'b0, 8'($urandom), 1'b0, 8'h00);

    // Reset during the third data bit of 0x0F aborts the frame.
    push_frame(0, 8'h0F);
    step(1'b1, 8'h0F, 1'b0, 8'h00);
    repeat (13) step(1'b0, 8'h00, 1'b0, 8'h00);
    reset = 1'b1;
    #1;
    chk("abort_tx_out", {31'd0, tx_out0}, 32'd1);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_ready", {31'd0, tx_ready0}, 32'd1);
    chk("abort_done", {31'd0, done0}, 32'd0);
    sb0.delete();
    #1 reset = 1'b0;
    push_idle(0, 3);
    while (sb0.size() > 0) step(1'b0, 8'h00, 1'b0, 8'h00);
    push_frame(0, 8'h81);
    push_idle(0, 1);
    step(1'b1, 8'h81, 1'b0, 8'h00);
    while (sb0.size() > 0) step(1'b0, 8'h00, 1'b0, 8'h00);

    // BIT_CYCLES=1 instance: 0x55, one clock per bit.
    push_idle(0, 14);
    push_frame(1, 8'h55);
    step(1'b0, 8'h00, 1'b1, 8'h55);
    while (sb1.size() > 0) step(1'b0, 8'h00, 1'b0, 8'h00);
    while (sb0.size() > 0) step(1'b0, 8'h00, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
